// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: sizing, opcode encoding and FSM states.
package alu_seq_pkg;

   localparam int DATA_W  = 16;
   localparam int REG_CNT = 8;
   localparam int ADDR_W  = $clog2(REG_CNT);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SLL  = 4'd2;
   localparam logic [3:0] OP_SRL  = 4'd3;
   localparam logic [3:0] OP_SRA  = 4'd4;
   localparam logic [3:0] OP_ROL  = 4'd5;
   localparam logic [3:0] OP_ROR  = 4'd6;
   localparam logic [3:0] OP_AND  = 4'd7;
   localparam logic [3:0] OP_OR   = 4'd8;
   localparam logic [3:0] OP_NAND = 4'd9;
   localparam logic [3:0] OP_NOR  = 4'd10;
   localparam logic [3:0] OP_XOR  = 4'd11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_e;

   // Codes above XOR have no ALU meaning and are retired with err.
   function automatic logic op_legal(input logic [3:0] op);
      return op <= OP_XOR;
   endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 8x16 register file: two operand read ports, a debug read port, one write port.
// Entry 0 is never written and always reads back as zero.
module alu_seq_regfile
   import alu_seq_pkg::*;
#(
   parameter int DW = alu_seq_pkg::DATA_W,
   parameter int RC = alu_seq_pkg::REG_CNT,
   parameter int AW = $clog2(RC)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr_a,
   output logic [DW-1:0] rdata_a,
   input  logic [AW-1:0] raddr_b,
   output logic [DW-1:0] rdata_b,
   input  logic [AW-1:0] raddr_dbg,
   output logic [DW-1:0] rdata_dbg
);

   logic [DW-1:0] mem_q [RC];
   logic [DW-1:0] mem_d [RC];

   always_comb begin
      mem_d = mem_q;
      if (we && (waddr != '0)) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata_a   = (raddr_a   == '0) ? '0 : mem_q[raddr_a];
   assign rdata_b   = (raddr_b   == '0) ? '0 : mem_q[raddr_b];
   assign rdata_dbg = (raddr_dbg == '0) ? '0 : mem_q[raddr_dbg];

endmodule

// File: rtl/alu_sequencer.sv
// Three-phase instruction sequencer feeding an external ALU and writing back to a local register file.
//
//   state  | meaning
//   IDLE   | ready for an instruction; operands latched on accept
//   EXEC   | ALU driven with latched operands; result and cc captured on exit
//   WB     | done pulse; result to R[rd] and cc to flags on exit (skipped on err)
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W  = alu_seq_pkg::DATA_W,
   parameter int REG_CNT = alu_seq_pkg::REG_CNT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       instr_valid,
   output logic                       instr_ready,
   input  logic [3:0]                 instr_op,
   input  logic [$clog2(REG_CNT)-1:0] instr_rd,
   input  logic [$clog2(REG_CNT)-1:0] instr_ra,
   input  logic [$clog2(REG_CNT)-1:0] instr_rb,
   input  logic                       instr_imm_en,
   input  logic [DATA_W-1:0]          instr_imm,
   output logic [DATA_W-1:0]          alu_valA,
   output logic [DATA_W-1:0]          alu_valB,
   output logic [3:0]                 alu_aluop,
   output logic                       alu_sub,
   output logic                       alu_shift_dir,
   output logic                       alu_rot_dir,
   input  logic [DATA_W-1:0]          alu_result,
   input  logic [3:0]                 alu_cc,
   output logic                       done,
   output logic                       err,
   output logic [3:0]                 flags,
   input  logic [$clog2(REG_CNT)-1:0] dbg_addr,
   output logic [DATA_W-1:0]          dbg_data
);

   localparam int AW = $clog2(REG_CNT);

   state_e              state_q, state_d;
   logic [AW-1:0]       rd_q, rd_d;
   logic                err_q, err_d;
   logic                done_q, done_d;
   logic [DATA_W-1:0]   res_q, res_d;
   logic [3:0]          cc_q, cc_d;
   logic [3:0]          flags_q, flags_d;
   logic [DATA_W-1:0]   alu_vala_q, alu_vala_d;
   logic [DATA_W-1:0]   alu_valb_q, alu_valb_d;
   logic [3:0]          alu_aluop_q, alu_aluop_d;
   logic                alu_sub_q, alu_sub_d;
   logic                alu_shift_dir_q, alu_shift_dir_d;
   logic                alu_rot_dir_q, alu_rot_dir_d;

   logic                wb_we;
   logic [DATA_W-1:0]   rdata_a, rdata_b;

   alu_seq_regfile #(
      .DW (DATA_W),
      .RC (REG_CNT),
      .AW (AW)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .we        (wb_we),
      .waddr     (rd_q),
      .wdata     (res_q),
      .raddr_a   (instr_ra),
      .rdata_a   (rdata_a),
      .raddr_b   (instr_rb),
      .rdata_b   (rdata_b),
      .raddr_dbg (dbg_addr),
      .rdata_dbg (dbg_data)
   );

   // ALU drive registers default to zero so they clear on every EXEC exit.
   always_comb begin
      state_d         = state_q;
      rd_d            = rd_q;
      err_d           = err_q;
      res_d           = res_q;
      cc_d            = cc_q;
      flags_d         = flags_q;
      done_d          = 1'b0;
      alu_vala_d      = '0;
      alu_valb_d      = '0;
      alu_aluop_d     = '0;
      alu_sub_d       = 1'b0;
      alu_shift_dir_d = 1'b0;
      alu_rot_dir_d   = 1'b0;
      wb_we           = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               rd_d = instr_rd;
               if (op_legal(instr_op)) begin
                  state_d         = S_EXEC;
                  err_d           = 1'b0;
                  alu_vala_d      = rdata_a;
                  alu_valb_d      = instr_imm_en ? instr_imm : rdata_b;
                  alu_aluop_d     = instr_op;
                  alu_sub_d       = (instr_op == OP_SUB);
                  alu_shift_dir_d = (instr_op == OP_SRL) || (instr_op == OP_SRA);
                  alu_rot_dir_d   = (instr_op == OP_ROR);
               end else begin
                  state_d = S_WB;
                  err_d   = 1'b1;
                  done_d  = 1'b1;
               end
            end
         end
         S_EXEC: begin
            res_d   = alu_result;
            cc_d    = alu_cc;
            state_d = S_WB;
            done_d  = 1'b1;
         end
         S_WB: begin
            state_d = S_IDLE;
            if (!err_q) begin
               flags_d = cc_q;
               wb_we   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         rd_q            <= '0;
         err_q           <= 1'b0;
         done_q          <= 1'b0;
         res_q           <= '0;
         cc_q            <= '0;
         flags_q         <= '0;
         alu_vala_q      <= '0;
         alu_valb_q      <= '0;
         alu_aluop_q     <= '0;
         alu_sub_q       <= 1'b0;
         alu_shift_dir_q <= 1'b0;
         alu_rot_dir_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         rd_q            <= rd_d;
         err_q           <= err_d;
         done_q          <= done_d;
         res_q           <= res_d;
         cc_q            <= cc_d;
         flags_q         <= flags_d;
         alu_vala_q      <= alu_vala_d;
         alu_valb_q      <= alu_valb_d;
         alu_aluop_q     <= alu_aluop_d;
         alu_sub_q       <= alu_sub_d;
         alu_shift_dir_q <= alu_shift_dir_d;
         alu_rot_dir_q   <= alu_rot_dir_d;
      end
   end

   // A reset landing in WB suppresses the pulse that is already on the wire.
   assign instr_ready   = (state_q == S_IDLE) && !rst;
   assign done          = done_q && !rst;
   assign err           = err_q && done;
   assign flags         = flags_q;
   assign alu_valA      = alu_vala_q;
   assign alu_valB      = alu_valb_q;
   assign alu_aluop     = alu_aluop_q;
   assign alu_sub       = alu_sub_q;
   assign alu_shift_dir = alu_shift_dir_q;
   assign alu_rot_dir   = alu_rot_dir_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural model of the external ALU.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   logic        clk;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [3:0]  instr_op;
   logic [2:0]  instr_rd, instr_ra, instr_rb;
   logic        instr_imm_en;
   logic [15:0] instr_imm;
   logic [15:0] alu_valA, alu_valB;
   logic [3:0]  alu_aluop;
   logic        alu_sub, alu_shift_dir, alu_rot_dir;
   logic [15:0] alu_result;
   logic [3:0]  alu_cc;
   logic        done, err;
   logic [3:0]  flags;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] s_vala, s_valb;
   logic [3:0]  s_aluop;
   logic        s_sub, s_shift, s_rot, s_err;
   int          s_lat;

   alu_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr_op      (instr_op),
      .instr_rd      (instr_rd),
      .instr_ra      (instr_ra),
      .instr_rb      (instr_rb),
      .instr_imm_en  (instr_imm_en),
      .instr_imm     (instr_imm),
      .alu_valA      (alu_valA),
      .alu_valB      (alu_valB),
      .alu_aluop     (alu_aluop),
      .alu_sub       (alu_sub),
      .alu_shift_dir (alu_shift_dir),
      .alu_rot_dir   (alu_rot_dir),
      .alu_result    (alu_result),
      .alu_cc        (alu_cc),
      .done          (done),
      .err           (err),
      .flags         (flags),
      .dbg_addr      (dbg_addr),
      .dbg_data      (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External ALU model: cc = {N,Z,C,V}; C is carry for ADD and borrow for SUB.
   logic [16:0] m_s17;
   logic [31:0] m_dbl;
   logic        m_c, m_v;
   always_comb begin
      m_s17      = '0;
      m_dbl      = {alu_valA, alu_valA};
      m_c        = 1'b0;
      m_v        = 1'b0;
      alu_result = '0;
      case (alu_aluop)
         4'd0: begin
            m_s17      = {1'b0, alu_valA} + {1'b0, alu_valB};
            alu_result = m_s17[15:0];
            m_c        = m_s17[16];
            m_v        = (alu_valA[15] == alu_valB[15]) && (alu_result[15] != alu_valA[15]);
         end
         4'd1: begin
            m_s17      = {1'b0, alu_valA} - {1'b0, alu_valB};
            alu_result = m_s17[15:0];
            m_c        = m_s17[16];
            m_v        = (alu_valA[15] != alu_valB[15]) && (alu_result[15] != alu_valA[15]);
         end
         4'd3:    alu_result = alu_valA >> alu_valB[3:0];
         4'd6: begin
            m_dbl      = m_dbl >> alu_valB[3:0];
            alu_result = m_dbl[15:0];
         end
         default: alu_result = alu_valA ^ alu_valB;
      endcase
      alu_cc = {alu_result[15], (alu_result == 16'h0000), m_c, m_v};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
      @(negedge clk);
      dbg_addr = a;
      #1;
      check(tag, {16'h0, dbg_data}, {16'h0, exp});
   endtask

   task automatic do_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                           input logic [2:0] rb, input logic ie, input logic [15:0] imm);
      bit got;
      check("ready_before_accept", {31'h0, instr_ready}, 32'd1);
      instr_op     = op;
      instr_rd     = rd;
      instr_ra     = ra;
      instr_rb     = rb;
      instr_imm_en = ie;
      instr_imm    = imm;
      instr_valid  = 1'b1;
      @(posedge clk); #1;
      instr_valid  = 1'b0;
      instr_op     = 4'd0;
      instr_rd     = 3'd7;
      s_vala  = alu_valA;
      s_valb  = alu_valB;
      s_aluop = alu_aluop;
      s_sub   = alu_sub;
      s_shift = alu_shift_dir;
      s_rot   = alu_rot_dir;
      s_err   = 1'b0;
      s_lat   = 0;
      got     = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if (!got) begin
            if (done) begin
               got   = 1'b1;
               s_lat = i;
               s_err = err;
            end else begin
               @(posedge clk); #1;
            end
         end
      end
      check("done_seen", {31'h0, got}, 32'd1);
      @(posedge clk); #1;
   endtask

   logic [3:0]  b_op  [4];
   logic [2:0]  b_rd  [4];
   logic [2:0]  b_ra  [4];
   logic [2:0]  b_rb  [4];
   logic        b_ie  [4];
   logic [15:0] b_imm [4];
   int          acc   [4];

   initial begin
      int  idx;
      int  cyc;
      bit  rdy;

      rst          = 1'b1;
      instr_valid  = 1'b0;
      instr_op     = '0;
      instr_rd     = '0;
      instr_ra     = '0;
      instr_rb     = '0;
      instr_imm_en = 1'b0;
      instr_imm    = '0;
      dbg_addr     = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready",  {31'h0, instr_ready}, 32'd0);
      check("rst_done",   {31'h0, done}, 32'd0);
      check("rst_flags",  {28'h0, flags}, 32'd0);
      check("rst_alu_a",  {16'h0, alu_valA}, 32'd0);
      check_reg("rst_r3", 3'd3, 16'h0000);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("ready_after_rst", {31'h0, instr_ready}, 32'd1);

      // Preload R1, R2 through immediate adds
      do_instr(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF);
      do_instr(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0001);
      check_reg("pre_r1", 3'd1, 16'h7FFF);
      check_reg("pre_r2", 3'd2, 16'h0001);

      do_instr(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000);
      check("add_aluop", {28'h0, s_aluop}, 32'd0);
      check("add_vala",  {16'h0, s_vala}, 32'h7FFF);
      check("add_valb",  {16'h0, s_valb}, 32'h0001);
      check("add_sub",   {31'h0, s_sub}, 32'd0);
      check("add_lat",   s_lat, 32'd2);
      check("add_err",   {31'h0, s_err}, 32'd0);
      check("add_flags", {28'h0, flags}, 32'b1001);
      check_reg("add_r3", 3'd3, 16'h8000);

      do_instr(OP_SUB, 3'd4, 3'd2, 3'd2, 1'b0, 16'h0000);
      check("sub_sub",   {31'h0, s_sub}, 32'd1);
      check("sub_aluop", {28'h0, s_aluop}, 32'd1);
      check("sub_flags", {28'h0, flags}, 32'b0100);
      check_reg("sub_r4", 3'd4, 16'h0000);

      do_instr(4'd13, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000);
      check("ill_vala",  {16'h0, s_vala}, 32'd0);
      check("ill_valb",  {16'h0, s_valb}, 32'd0);
      check("ill_aluop", {28'h0, s_aluop}, 32'd0);
      check("ill_lat",   s_lat, 32'd1);
      check("ill_err",   {31'h0, s_err}, 32'd1);
      check("ill_flags", {28'h0, flags}, 32'b0100);
      check_reg("ill_r3", 3'd3, 16'h8000);
      check_reg("ill_r1", 3'd1, 16'h7FFF);

      do_instr(OP_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0005);
      check("r0_valb",  {16'h0, s_valb}, 32'h0005);
      check("r0_flags", {28'h0, flags}, 32'b0000);
      check_reg("r0_zero", 3'd0, 16'h0000);

      do_instr(OP_ROR, 3'd5, 3'd1, 3'd2, 1'b0, 16'h0000);
      check("ror_rot",   {31'h0, s_rot}, 32'd1);
      check("ror_shift", {31'h0, s_shift}, 32'd0);
      check_reg("ror_r5", 3'd5, 16'hBFFF);

      do_instr(OP_SRL, 3'd6, 3'd3, 3'd0, 1'b1, 16'h0004);
      check("srl_shift", {31'h0, s_shift}, 32'd1);
      check("srl_rot",   {31'h0, s_rot}, 32'd0);
      check_reg("srl_r6", 3'd6, 16'h0800);

      // Reset in EXEC of a write to R5
      @(posedge clk); #1;
      instr_op = OP_ADD; instr_rd = 3'd5; instr_ra = 3'd1; instr_rb = 3'd2;
      instr_imm_en = 1'b0; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      check("abort_in_exec", {16'h0, alu_valA}, 32'h7FFF);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_done_rst",  {31'h0, done}, 32'd0);
      check("abort_ready_rst", {31'h0, instr_ready}, 32'd0);
      rst = 1'b0;
      #1;
      check("abort_ready", {31'h0, instr_ready}, 32'd1);
      check("abort_done",  {31'h0, done}, 32'd0);
      check("abort_flags", {28'h0, flags}, 32'd0);
      check_reg("abort_r5", 3'd5, 16'h0000);
      check("abort_done_later", {31'h0, done}, 32'd0);

      // Back-to-back with instr_valid held high
      b_op  = '{OP_ADD, OP_ADD, OP_ADD, OP_SUB};
      b_rd  = '{3'd1, 3'd2, 3'd3, 3'd4};
      b_ra  = '{3'd0, 3'd1, 3'd2, 3'd3};
      b_rb  = '{3'd0, 3'd0, 3'd1, 3'd1};
      b_ie  = '{1'b1, 1'b1, 1'b0, 1'b0};
      b_imm = '{16'd3, 16'd4, 16'd0, 16'd0};
      acc   = '{0, 0, 0, 0};
      @(posedge clk); #1;
      idx = 0;
      cyc = 0;
      instr_op = b_op[0]; instr_rd = b_rd[0]; instr_ra = b_ra[0];
      instr_rb = b_rb[0]; instr_imm_en = b_ie[0]; instr_imm = b_imm[0];
      instr_valid = 1'b1;
      while (idx < 4 && cyc < 30) begin
         rdy = instr_ready;
         @(posedge clk); #1;
         cyc++;
         if (rdy) begin
            acc[idx] = cyc;
            idx++;
            if (idx < 4) begin
               instr_op = b_op[idx]; instr_rd = b_rd[idx]; instr_ra = b_ra[idx];
               instr_rb = b_rb[idx]; instr_imm_en = b_ie[idx]; instr_imm = b_imm[idx];
            end
         end
      end
      instr_valid = 1'b0;
      check("b2b_accepted", idx, 32'd4);
      check("b2b_gap01", acc[1] - acc[0], 32'd3);
      check("b2b_gap12", acc[2] - acc[1], 32'd3);
      check("b2b_gap23", acc[3] - acc[2], 32'd3);
      repeat (2) @(posedge clk);
      #1;
      check_reg("b2b_r1", 3'd1, 16'd3);
      check_reg("b2b_r2", 3'd2, 16'd7);
      check_reg("b2b_r3", 3'd3, 16'd10);
      check_reg("b2b_r4", 3'd4, 16'd7);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, 16, operand/result width.
REQ-002 SHALL have parameter REG_CNT, 8, register-file depth (addresses 3 bits).
REQ-003 SHALL have ports: clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have: instr_valid in 1, instr_ready out 1; valid/ready instruction handshake.
REQ-006 SHALL have: instr_op in 4, instr_rd in 3, instr_ra in 3, instr_rb in 3, instr_imm_en in 1, instr_imm in 16.
REQ-007 SHALL have: alu_valA out 16, alu_valB out 16, alu_aluop out 4, alu_sub out 1, alu_shift_dir out 1, alu_rot_dir out 1; drive the ALU.
REQ-008 SHALL have: alu_result in 16, alu_cc in 4 ({N,Z,C,V}); combinational return from the ALU.
REQ-009 SHALL have: done out 1 (one-cycle completion pulse), err out 1 (qualified by done), flags out 4 (last captured cc).
REQ-010 SHALL have: dbg_addr in 3, dbg_data out 16; combinational register read port.

Function
REQ-011 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; instr_ready = 1 only in IDLE and rst low.
REQ-012 On valid&ready edge SHALL latch op, rd, A = R[ra], B = imm_en ? imm : R[rb]; go to EXEC (op 0-11) or WB with err pending (op 12-15).
REQ-013 In EXEC (exactly one cycle) SHALL drive alu_valA=A, alu_valB=B, alu_aluop=op; alu_sub=1 only for op 1; alu_shift_dir=1 (right) for ops 3,4, else 0; alu_rot_dir=1 for op 6, else 0.
REQ-014 At the EXEC->WB edge SHALL capture alu_result and alu_cc.
REQ-015 In WB SHALL assert done for one cycle, write captured result to R[rd] and captured cc to flags at the WB->IDLE edge.
REQ-016 Outside EXEC all alu_* outputs SHALL be 0.
REQ-017 R0 SHALL read as 0; writes to rd=0 discarded, flags still updated.
REQ-018 Illegal op (12-15): no ALU drive, done=1 with err=1, no register write, flags unchanged.
REQ-019 Latency: accept edge E0, done high in cycle after E1, write visible on dbg_data after E2; max throughput one instruction per 3 cycles.
REQ-020 instr_* fields SHALL be ignored when instr_ready=0; no buffering of a second instruction.
REQ-021 Read-after-write across back-to-back instructions SHALL see the new value (write completes before next accept).

Reset
REQ-022 While rst=1 at a clock edge: state=IDLE, all registers R0-R7=0, flags=0, done=0, err=0, latched operands=0.
REQ-023 rst during EXEC or WB SHALL abort: no register write, no flags update, no done pulse.
REQ-024 instr_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.

Structure
REQ-025 Package alu_seq_pkg SHALL hold DATA_W, REG_CNT, the 4-bit op encoding constants (ADD=0 ... XOR=11) and the FSM state encoding.
REQ-026 Register file SHALL be sub-module alu_seq_regfile: 8x16, two combinational read ports plus debug read, one synchronous write port, R0 hard zero.
REQ-027 ALU is external; this block contains no arithmetic datapath.

Verification
REQ-028 Preload R1=0x7FFF, R2=0x0001; ADD rd=3 -> alu_aluop=0 in EXEC, R3=0x8000, flags=1001 (N,V set), done 2 cycles after accept.
REQ-029 SUB rd=4 ra=2 rb=2 -> alu_sub=1 in EXEC, R4=0x0000, flags Z=1.
REQ-030 op=13 -> no alu drive (all zero), done=1 err=1, all registers and flags unchanged.
REQ-031 ADD imm_en=1 imm=0x0005 ra=0 rd=0 -> R0 still reads 0, flags=0000; then op 6 (ROR) -> alu_rot_dir=1.
REQ-032 Assert rst in EXEC of a write to R5 -> R5=0, no done, instr_ready=1 cycle after rst release.
REQ-033 instr_valid held high for 4 back-to-back instructions -> accepts exactly every 3rd cycle, second instruction reads first's result.
